// File: rtl/xc_sha3_lane_seq.sv
// Keccak lane address sequencer: walks the 25 lanes of one state pass (y outer, x inner),
// drives the xc.sha3 index unit and registers base+index as a valid/ready address stream.
//
//  state | meaning
//  IDLE  | waiting for start with a legal mode; index function strobes all low
//  RUN   | output register holds a beat; counters hold the next beat to load

module xc_sha3_lane_seq #(
    parameter logic [1:0] LANE_SHAMT = 2'd3
) (
    input  logic        g_clk,
    input  logic        g_reset,
    input  logic        start,
    input  logic [2:0]  mode,
    input  logic [31:0] base_addr,
    input  logic        abort,
    output logic [31:0] idx_rs1,
    output logic [31:0] idx_rs2,
    output logic [1:0]  idx_shamt,
    output logic        idx_f_xy,
    output logic        idx_f_x1,
    output logic        idx_f_x2,
    output logic        idx_f_x4,
    output logic        idx_f_yx,
    input  logic [31:0] idx_result,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_addr,
    output logic [2:0]  out_x,
    output logic [2:0]  out_y,
    output logic        out_last,
    output logic        busy,
    output logic        done
);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t      state;
    logic [2:0]  x;
    logic [2:0]  y;
    logic        more;
    logic [31:0] base_q;
    logic [4:0]  fn_q;

    logic        mode_legal;
    logic [4:0]  mode_onehot;
    logic [2:0]  first_lhs;
    logic [31:0] first_idx;
    logic        accept;
    logic        load;

    assign idx_rs1   = {29'b0, x};
    assign idx_rs2   = {29'b0, y};
    assign idx_shamt = LANE_SHAMT;
    assign idx_f_xy  = fn_q[0];
    assign idx_f_x1  = fn_q[1];
    assign idx_f_x2  = fn_q[2];
    assign idx_f_x4  = fn_q[3];
    assign idx_f_yx  = fn_q[4];

    assign accept = out_valid & out_ready;
    assign load   = (~out_valid | accept) & more;

    // Beat 0 is (0,0) for every mode, so its index is a constant per mode and the
    // index unit does not have to be driven before the mode is latched.
    always_comb begin
        mode_legal  = (mode <= 3'd4);
        mode_onehot = 5'd0;
        first_lhs   = 3'd0;
        case (mode)
            3'd0: mode_onehot = 5'b00001;
            3'd1: begin mode_onehot = 5'b00010; first_lhs = 3'd1; end
            3'd2: begin mode_onehot = 5'b00100; first_lhs = 3'd2; end
            3'd3: begin mode_onehot = 5'b01000; first_lhs = 3'd4; end
            3'd4: mode_onehot = 5'b10000;
            default: mode_onehot = 5'd0;
        endcase
        first_idx = {29'b0, first_lhs} << LANE_SHAMT;
    end

    always_ff @(posedge g_clk) begin
        if (g_reset) begin
            state     <= IDLE;
            x         <= 3'd0;
            y         <= 3'd0;
            more      <= 1'b0;
            base_q    <= 32'd0;
            fn_q      <= 5'd0;
            out_valid <= 1'b0;
            out_addr  <= 32'd0;
            out_x     <= 3'd0;
            out_y     <= 3'd0;
            out_last  <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start && mode_legal) begin
                        state     <= RUN;
                        busy      <= 1'b1;
                        base_q    <= base_addr;
                        fn_q      <= mode_onehot;
                        out_valid <= 1'b1;
                        out_addr  <= base_addr + first_idx;
                        out_x     <= 3'd0;
                        out_y     <= 3'd0;
                        out_last  <= 1'b0;
                        x         <= 3'd1;
                        y         <= 3'd0;
                        more      <= 1'b1;
                    end
                end
                RUN: begin
                    if (abort || (accept && out_last)) begin
                        state     <= IDLE;
                        busy      <= 1'b0;
                        out_valid <= 1'b0;
                        out_last  <= 1'b0;
                        fn_q      <= 5'd0;
                        x         <= 3'd0;
                        y         <= 3'd0;
                        more      <= 1'b0;
                        done      <= ~abort;
                    end else if (load) begin
                        out_valid <= 1'b1;
                        out_addr  <= base_q + idx_result;
                        out_x     <= x;
                        out_y     <= y;
                        out_last  <= (x == 3'd4) && (y == 3'd4);
                        // counters park on (4,4) once the final lane is loaded
                        if (x == 3'd4) begin
                            if (y == 3'd4) begin
                                more <= 1'b0;
                            end else begin
                                x <= 3'd0;
                                y <= y + 3'd1;
                            end
                        end else begin
                            x <= x + 3'd1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_xc_sha3_lane_seq.sv
// Self-checking bench for xc_sha3_lane_seq: stubs the index unit and checks every beat
// against lane addresses computed from the beat number.

module tb_xc_sha3_lane_seq;

    logic        g_clk = 1'b0;
    logic        g_reset, start, abort, out_ready;
    logic [2:0]  mode;
    logic [31:0] base_addr, idx_result;
    logic [31:0] idx_rs1, idx_rs2, out_addr;
    logic [1:0]  idx_shamt;
    logic        idx_f_xy, idx_f_x1, idx_f_x2, idx_f_x4, idx_f_yx;
    logic        out_valid, out_last, busy, done;
    logic [2:0]  out_x, out_y;
    logic [4:0]  fvec;

    int checks = 0;
    int errors = 0;

    xc_sha3_lane_seq #(.LANE_SHAMT(2'd3)) dut (
        .g_clk(g_clk), .g_reset(g_reset), .start(start), .mode(mode),
        .base_addr(base_addr), .abort(abort),
        .idx_rs1(idx_rs1), .idx_rs2(idx_rs2), .idx_shamt(idx_shamt),
        .idx_f_xy(idx_f_xy), .idx_f_x1(idx_f_x1), .idx_f_x2(idx_f_x2),
        .idx_f_x4(idx_f_x4), .idx_f_yx(idx_f_yx), .idx_result(idx_result),
        .out_valid(out_valid), .out_ready(out_ready), .out_addr(out_addr),
        .out_x(out_x), .out_y(out_y), .out_last(out_last), .busy(busy), .done(done)
    );

    always #5 g_clk = ~g_clk;

    assign fvec = {idx_f_yx, idx_f_x4, idx_f_x2, idx_f_x1, idx_f_xy};

    // Lane index as the index unit defines it, for mode 0..4 = XY, X1, X2, X4, YX.
    function automatic logic [31:0] lane_idx(input int m, input int x, input int y, input int sh);
        int lhs, rhs;
        case (m)
            1: begin lhs = x + 1; rhs = y; end
            2: begin lhs = x + 2; rhs = y; end
            3: begin lhs = x + 4; rhs = y; end
            4: begin lhs = y; rhs = 2 * x + 3 * y; end
            default: begin lhs = x; rhs = y; end
        endcase
        return 32'((lhs % 5) + 5 * (rhs % 5)) << sh;
    endfunction

    // Index unit stub
    always_comb begin
        idx_result = 32'd0;
        case (fvec)
            5'b00001: idx_result = lane_idx(0, int'(idx_rs1), int'(idx_rs2), int'(idx_shamt));
            5'b00010: idx_result = lane_idx(1, int'(idx_rs1), int'(idx_rs2), int'(idx_shamt));
            5'b00100: idx_result = lane_idx(2, int'(idx_rs1), int'(idx_rs2), int'(idx_shamt));
            5'b01000: idx_result = lane_idx(3, int'(idx_rs1), int'(idx_rs2), int'(idx_shamt));
            5'b10000: idx_result = lane_idx(4, int'(idx_rs1), int'(idx_rs2), int'(idx_shamt));
            default:  idx_result = 32'd0;
        endcase
    end

    function automatic logic [31:0] beat_addr(input int m, input logic [31:0] base, input int n);
        return base + lane_idx(m, n % 5, n / 5, 3);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge g_clk);
        #1;
    endtask

    task automatic start_pass(input int m, input logic [31:0] base);
        mode      = 3'(m);
        base_addr = base;
        start     = 1'b1;
        tick();
        start     = 1'b0;
        chk("start_latency_valid", {31'd0, out_valid}, 32'd1);
    endtask

    // Consume beats n = 0 .. stop-1 of an accepted pass, checking every presented beat.
    task automatic drain(input int m, input logic [31:0] base, input int stop,
                         input bit rnd, input bit junk, output int cycles);
        int n = 0;
        bit r;
        cycles = 0;
        while (n < stop && cycles < 400) begin
            chk("beat_valid", {31'd0, out_valid}, 32'd1);
            chk("beat_busy", {31'd0, busy}, 32'd1);
            chk("beat_addr", out_addr, beat_addr(m, base, n));
            chk("beat_x", {29'd0, out_x}, 32'(n % 5));
            chk("beat_y", {29'd0, out_y}, 32'(n / 5));
            chk("beat_last", {31'd0, out_last}, (n == 24) ? 32'd1 : 32'd0);
            chk("beat_fn", {27'd0, fvec}, 32'(1 << m));
            r = rnd ? ($urandom_range(3) != 0) : 1'b1;
            out_ready = r;
            if (junk) begin
                start     = $urandom_range(1);
                mode      = 3'($urandom_range(7));
                base_addr = $urandom;
            end
            tick();
            cycles++;
            if (r) n++;
        end
        start     = 1'b0;
        out_ready = 1'b0;
        if (cycles >= 400) chk("drain_timeout", 32'(n), 32'(stop));
        if (stop == 25) begin
            chk("done_pulse", {31'd0, done}, 32'd1);
            chk("done_busy", {31'd0, busy}, 32'd0);
            chk("done_valid", {31'd0, out_valid}, 32'd0);
            chk("done_fn_idle", {27'd0, fvec}, 32'd0);
        end
    endtask

    typedef struct {
        int          m;
        logic [31:0] base;
        int          n;
        logic [31:0] exp_addr;
    } vec_t;

    vec_t tbl[8];
    int   cyc;
    int   m_r;
    logic [31:0] b_r;

    initial begin
        tbl[0] = '{0, 32'h0000_1000, 0,  32'h0000_1000};
        tbl[1] = '{0, 32'h0000_1000, 1,  32'h0000_1008};
        tbl[2] = '{0, 32'h0000_1000, 24, 32'h0000_10C0};
        tbl[3] = '{4, 32'h0000_2000, 1,  32'h0000_2050};
        tbl[4] = '{3, 32'h0000_0000, 1,  32'h0000_0000};
        tbl[5] = '{1, 32'h0000_0000, 14, 32'h0000_0050};
        tbl[6] = '{2, 32'h0000_0000, 3,  32'h0000_0000};
        tbl[7] = '{0, 32'hFFFF_FFF8, 1,  32'h0000_0000};

        g_reset = 1'b1; start = 1'b0; abort = 1'b0; out_ready = 1'b0;
        mode = 3'd0; base_addr = 32'd0;
        tick(); tick();
        g_reset = 1'b0;
        tick();
        chk("rst_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_addr", out_addr, 32'd0);
        chk("rst_xy", {26'd0, out_x, out_y}, 32'd0);
        chk("rst_last", {31'd0, out_last}, 32'd0);
        chk("rst_busy_done", {30'd0, busy, done}, 32'd0);
        chk("rst_fn", {27'd0, fvec}, 32'd0);
        chk("shamt", {30'd0, idx_shamt}, 32'd3);

        // table vectors: step to the beat with ready=1, compare, then abort the pass
        foreach (tbl[i]) begin
            start_pass(tbl[i].m, tbl[i].base);
            out_ready = 1'b1;
            for (int k = 0; k < tbl[i].n; k++) tick();
            out_ready = 1'b0;
            chk($sformatf("tbl%0d_addr", i), out_addr, tbl[i].exp_addr);
            chk($sformatf("tbl%0d_xy", i), {26'd0, out_x, out_y},
                32'({3'(tbl[i].n % 5), 3'(tbl[i].n / 5)}));
            chk($sformatf("tbl%0d_last", i), {31'd0, out_last}, (tbl[i].n == 24) ? 32'd1 : 32'd0);
            abort = 1'b1;
            tick();
            abort = 1'b0;
            chk($sformatf("tbl%0d_abort_idle", i), {30'd0, busy, out_valid}, 32'd0);
            chk($sformatf("tbl%0d_abort_nodone", i), {31'd0, done}, 32'd0);
        end

        // full-throughput XY pass, immediately followed by a start in the done cycle
        start_pass(0, 32'h0000_1000);
        drain(0, 32'h0000_1000, 25, 1'b0, 1'b0, cyc);
        chk("throughput_cycles", 32'(cyc), 32'd25);
        start_pass(4, 32'h0000_2000);
        drain(4, 32'h0000_2000, 25, 1'b0, 1'b0, cyc);

        // stall three cycles on beat 7
        start_pass(0, 32'h0000_3000);
        out_ready = 1'b1;
        for (int k = 0; k < 7; k++) tick();
        out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("stall_addr", out_addr, 32'h0000_3038);
            chk("stall_xy", {26'd0, out_x, out_y}, {26'd0, 3'd2, 3'd1});
            chk("stall_valid", {31'd0, out_valid}, 32'd1);
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("after_stall_addr", out_addr, 32'h0000_3040);
        chk("after_stall_xy", {26'd0, out_x, out_y}, {26'd0, 3'd3, 3'd1});
        abort = 1'b1; tick(); abort = 1'b0;

        // abort at beat 12 (together with an accept), then a fresh pass
        start_pass(0, 32'h0000_5000);
        out_ready = 1'b1;
        for (int k = 0; k < 12; k++) tick();
        abort = 1'b1;
        tick();
        abort = 1'b0; out_ready = 1'b0;
        chk("abort_valid", {31'd0, out_valid}, 32'd0);
        chk("abort_busy", {31'd0, busy}, 32'd0);
        chk("abort_done", {31'd0, done}, 32'd0);
        tick();
        chk("abort_done_later", {31'd0, done}, 32'd0);
        start_pass(0, 32'h0000_0040);
        chk("post_abort_beat0", out_addr, 32'h0000_0040);
        drain(0, 32'h0000_0040, 25, 1'b0, 1'b0, cyc);

        // abort while idle, then illegal modes
        tick();
        abort = 1'b1; tick(); abort = 1'b0;
        chk("idle_abort_busy", {30'd0, busy, out_valid}, 32'd0);
        for (int md = 5; md < 8; md++) begin
            mode = 3'(md); start = 1'b1; base_addr = 32'hDEAD_0000;
            tick();
            start = 1'b0;
            chk($sformatf("illegal_mode%0d", md), {29'd0, busy, out_valid, done}, 32'd0);
            chk($sformatf("illegal_mode%0d_fn", md), {27'd0, fvec}, 32'd0);
        end

        // synchronous reset in the middle of a stall
        start_pass(4, 32'h1234_5670);
        out_ready = 1'b1;
        for (int k = 0; k < 3; k++) tick();
        out_ready = 1'b0;
        tick();
        g_reset = 1'b1;
        tick();
        g_reset = 1'b0;
        chk("midrst_addr", out_addr, 32'd0);
        chk("midrst_flags", {28'd0, out_valid, out_last, busy, done}, 32'd0);
        chk("midrst_xy", {26'd0, out_x, out_y}, 32'd0);
        chk("midrst_idx", idx_rs1 | idx_rs2, 32'd0);
        chk("midrst_fn", {27'd0, fvec}, 32'd0);

        // randomized passes with random back-pressure and ignored starts while busy
        for (int p = 0; p < 8; p++) begin
            m_r = $urandom_range(4);
            b_r = (p == 0) ? 32'hFFFF_FF80 : $urandom;
            start_pass(m_r, b_r);
            drain(m_r, b_r, 25, 1'b1, 1'b1, cyc);
            if ($urandom_range(1) == 1) tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: got timeout expected finish");
        $fatal(1, "timeout");
    end

endmodule
